// File: rtl/drive_cmd_ctrl.sv
// Debounced IR/tin inputs -> slew-limited duty command and stop/status flags for the PWM stage; stop 1 clk after debounced obstacle, no backpressure.
// Optional DRIVE_CMD_RAMP_EN: defined = ramp 1 LSB per RAMP_DIV clocks; undefined = SLEW loads target in one clock.
module drive_cmd_ctrl #(
  parameter int unsigned DEB_CYCLES     = 16,
  parameter int unsigned DUTY_FAST      = 180,
  parameter int unsigned DUTY_SLOW      = 150,
  parameter int unsigned RAMP_DIV       = 64,
  parameter int unsigned RESTART_CYCLES = 256
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ir_raw,
  input  logic       tin_raw,
  output logic [7:0] duty,
  output logic       motor_en,
  output logic       obstacle,
  output logic       fast,
  output logic       at_speed
);

  typedef enum logic [2:0] {IDLE, SLEW, RUN, BLOCKED, HOLDOFF} state_t;

  if (DEB_CYCLES < 1 || DEB_CYCLES > 65535 || RAMP_DIV < 1 || RAMP_DIV > 65535 ||
      RESTART_CYCLES < 1 || RESTART_CYCLES > 65535 || DUTY_FAST > 255 || DUTY_SLOW > 255) begin : g_param_chk
    $error("drive_cmd_ctrl: parameter out of range");
  end

  state_t      state, state_nxt;
  logic [7:0]  duty_nxt;
  logic [7:0]  target;
  logic [1:0]  ir_sync, tin_sync;
  logic [15:0] ir_deb_cnt, tin_deb_cnt;
  logic [15:0] hold_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      ir_sync     <= '0;
      tin_sync    <= '0;
      ir_deb_cnt  <= '0;
      tin_deb_cnt <= '0;
      obstacle    <= 1'b0;
      fast        <= 1'b0;
    end else begin
      ir_sync  <= {ir_sync[0], ir_raw};
      tin_sync <= {tin_sync[0], tin_raw};
      // Flip only after DEB_CYCLES consecutive mismatching samples.
      if (ir_sync[1] == obstacle) begin
        ir_deb_cnt <= '0;
      end else if (ir_deb_cnt == 16'(DEB_CYCLES - 1)) begin
        ir_deb_cnt <= '0;
        obstacle   <= ir_sync[1];
      end else begin
        ir_deb_cnt <= ir_deb_cnt + 16'd1;
      end
      if (tin_sync[1] == fast) begin
        tin_deb_cnt <= '0;
      end else if (tin_deb_cnt == 16'(DEB_CYCLES - 1)) begin
        tin_deb_cnt <= '0;
        fast        <= tin_sync[1];
      end else begin
        tin_deb_cnt <= tin_deb_cnt + 16'd1;
      end
    end
  end

  assign target = fast ? 8'(DUTY_FAST) : 8'(DUTY_SLOW);

`ifdef DRIVE_CMD_RAMP_EN
  logic [15:0] pre_cnt;
  logic        tick;

  assign tick = (pre_cnt == 16'(RAMP_DIV - 1));

  // Prescaler restarts from zero on every entry into SLEW.
  always_ff @(posedge clk) begin
    if (rst)                                  pre_cnt <= '0;
    else if (state == SLEW && state_nxt == SLEW) pre_cnt <= tick ? 16'd0 : pre_cnt + 16'd1;
    else                                      pre_cnt <= '0;
  end
`endif

  always_comb begin
    state_nxt = state;
    duty_nxt  = duty;
    case (state)
      IDLE: begin
        duty_nxt  = 8'd0;
        state_nxt = obstacle ? BLOCKED : SLEW;
      end
      SLEW: begin
        if (obstacle) begin
          state_nxt = BLOCKED;
          duty_nxt  = 8'd0;
        end else if (duty == target) begin
          state_nxt = RUN;
        end else begin
`ifdef DRIVE_CMD_RAMP_EN
          if (tick) duty_nxt = (duty < target) ? duty + 8'd1 : duty - 8'd1;
`else
          duty_nxt = target;
`endif
        end
      end
      RUN: begin
        if (obstacle) begin
          state_nxt = BLOCKED;
          duty_nxt  = 8'd0;
        end else if (duty != target) begin
          state_nxt = SLEW;
        end
      end
      BLOCKED: begin
        duty_nxt = 8'd0;
        if (!obstacle) state_nxt = HOLDOFF;
      end
      HOLDOFF: begin
        duty_nxt = 8'd0;
        if (obstacle)                                    state_nxt = BLOCKED;
        else if (hold_cnt == 16'(RESTART_CYCLES - 1))    state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
        duty_nxt  = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      duty     <= 8'd0;
      motor_en <= 1'b0;
      at_speed <= 1'b0;
      hold_cnt <= '0;
    end else begin
      state    <= state_nxt;
      duty     <= duty_nxt;
      motor_en <= (state_nxt == SLEW) || (state_nxt == RUN);
      at_speed <= (state_nxt == RUN);
      // Counter only advances while staying in HOLDOFF, so any re-entry starts at zero.
      hold_cnt <= (state == HOLDOFF && state_nxt == HOLDOFF) ? hold_cnt + 16'd1 : 16'd0;
    end
  end

endmodule

// File: tb/tb_drive_cmd_ctrl.sv
// Directed bench for drive_cmd_ctrl with DEB_CYCLES=4, RAMP_DIV=2, RESTART_CYCLES=8.
module tb_drive_cmd_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       ir_raw;
  logic       tin_raw;
  logic [7:0] duty;
  logic       motor_en;
  logic       obstacle;
  logic       fast;
  logic       at_speed;

  int n_checks = 0;
  int n_errors = 0;

  drive_cmd_ctrl #(
    .DEB_CYCLES(4), .DUTY_FAST(180), .DUTY_SLOW(150), .RAMP_DIV(2), .RESTART_CYCLES(8)
  ) u_dut (
    .clk(clk), .rst(rst), .ir_raw(ir_raw), .tin_raw(tin_raw),
    .duty(duty), .motor_en(motor_en), .obstacle(obstacle), .fast(fast), .at_speed(at_speed)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  initial begin
    rst = 1'b1; ir_raw = 1'b0; tin_raw = 1'b0;
    step(3);
    chk("rst_duty", duty, 0);
    chk("rst_en", motor_en, 0);
    chk("rst_obs", obstacle, 0);
    chk("rst_fast", fast, 0);
    chk("rst_atspd", at_speed, 0);
    rst = 1'b0;

    // Soft start to the slow target.
    step(1);
    chk("start_en", motor_en, 1);
    chk("start_duty0", duty, 0);
`ifdef DRIVE_CMD_RAMP_EN
    step(2);   chk("start_duty1", duty, 1);   chk("start_atspd0", at_speed, 0);
    step(298); chk("start_duty150", duty, 150); chk("start_atspd_ramp", at_speed, 0);
    step(1);   chk("start_atspd1", at_speed, 1);
`else
    step(1);   chk("start_duty150", duty, 150); chk("start_atspd0", at_speed, 0);
    step(1);   chk("start_atspd1", at_speed, 1);
`endif
    step(5);
    chk("run_hold150", duty, 150);

    // tin rises: debounce latency 6, then ramp up to the fast target.
    tin_raw = 1'b1;
    step(5); chk("fast_early", fast, 0);
    step(1); chk("fast_rise", fast, 1);
    step(1); chk("up_atspd0", at_speed, 0); chk("up_duty_hold", duty, 150);
`ifdef DRIVE_CMD_RAMP_EN
    step(2);  chk("up_duty151", duty, 151);
    step(58); chk("up_duty180", duty, 180); chk("up_atspd_ramp", at_speed, 0);
    step(1);  chk("up_atspd1", at_speed, 1);
`else
    step(1);  chk("up_duty180", duty, 180); chk("up_atspd_jump", at_speed, 0);
    step(1);  chk("up_atspd1", at_speed, 1);
`endif

    // Three-sample IR glitch is rejected.
    ir_raw = 1'b1;
    step(3);
    ir_raw = 1'b0;
    step(10);
    chk("glitch_obs", obstacle, 0);
    chk("glitch_duty", duty, 180);
    chk("glitch_atspd", at_speed, 1);

    // tin falls: ramp down to the slow target.
    tin_raw = 1'b0;
    step(5); chk("slow_early", fast, 1);
    step(1); chk("slow_fall", fast, 0);
    step(1); chk("dn_atspd0", at_speed, 0);
`ifdef DRIVE_CMD_RAMP_EN
    step(2);  chk("dn_duty179", duty, 179);
    step(58); chk("dn_duty150", duty, 150);
    step(1);  chk("dn_atspd1", at_speed, 1);
`else
    step(1);  chk("dn_duty150", duty, 150);
    step(1);  chk("dn_atspd1", at_speed, 1);
`endif

    // Obstacle: stop one clock after debounced rise, holdoff, restart.
    ir_raw = 1'b1;
    step(5); chk("obs_early", obstacle, 0);
    step(1); chk("obs_rise", obstacle, 1); chk("obs_en_still", motor_en, 1); chk("obs_duty_still", duty, 150);
    step(1); chk("blk_duty", duty, 0); chk("blk_en", motor_en, 0); chk("blk_atspd", at_speed, 0);
    step(3);
    ir_raw = 1'b0;
    step(5); chk("clr_early", obstacle, 1);
    step(1); chk("clr_fall", obstacle, 0);
    step(9); chk("hold_en_last", motor_en, 0);
    step(1); chk("restart_en", motor_en, 1); chk("restart_duty0", duty, 0);
`ifdef DRIVE_CMD_RAMP_EN
    step(2); chk("restart_duty1", duty, 1);
`else
    step(1); chk("restart_duty150", duty, 150);
`endif

    // Re-block during HOLDOFF restarts the holdoff after the clear.
    ir_raw = 1'b1;
    step(7); chk("reblk_setup_en", motor_en, 0);
    ir_raw = 1'b0;
    step(8);
    ir_raw = 1'b1;
    step(6); chk("reblk_obs", obstacle, 1); chk("reblk_en_a", motor_en, 0);
    step(2); chk("reblk_en_b", motor_en, 0);
    step(2);
    ir_raw = 1'b0;
    step(6); chk("reblk_clr", obstacle, 0);
    step(9); chk("reblk_hold_last", motor_en, 0);
    step(1); chk("reblk_restart", motor_en, 1);

    // Reset mid-operation.
    step(3);
    rst = 1'b1;
    step(1);
    chk("midrst_duty", duty, 0);
    chk("midrst_en", motor_en, 0);
    chk("midrst_atspd", at_speed, 0);
    rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
